// File: rtl/float_horner_pipe_if.sv
// rtl/float_horner_pipe_if.sv - argument/result bundle for float_horner_pipe
`ifndef FLEN
`define FLEN 64
`endif

interface float_horner_pipe_if #(
    parameter int FLEN   = `FLEN,
    parameter int DEGREE = 2
);
    logic                       arg_vld;
    logic [FLEN-1:0]            x;
    logic [(DEGREE+1)*FLEN-1:0] coef;
    logic                       res_vld;
    logic [FLEN-1:0]            res;
    logic                       res_negative;
    logic                       err;
    logic                       busy;

    modport master (output arg_vld, x, coef, input res_vld, res, res_negative, err, busy);
    modport slave  (input arg_vld, x, coef, output res_vld, res, res_negative, err, busy);
endinterface

// File: rtl/float_horner_pipe.sv
// rtl/float_horner_pipe.sv - pipelined Horner polynomial evaluator with f_mult/f_add units
// Optional: FLOAT_HORNER_ERR_STICKY_EN makes err hold until reset.
`ifndef FLEN
`define FLEN 64
`endif

module hp_delay #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld_any
);
    logic [W-1:0] r [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r[i] <= '0;
        end else begin
            r[0] <= d;
            for (int i = 1; i < N; i++) r[i] <= r[i-1];
        end
    end

    assign q = r[N-1];

    // bit 0 of every carried word is its valid flag
    always_comb begin
        vld_any = 1'b0;
        for (int i = 0; i < N; i++) vld_any = vld_any | r[i][0];
    end
endmodule

module f_mult #(
    parameter int FLEN = 64,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            down_valid,
    output logic [FLEN-1:0] result,
    output logic            error,
    output logic            busy
);
    localparam int EW   = (FLEN == 32) ? 8 : 11;
    localparam int MW   = FLEN - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;

    logic [2*MW+1:0] pa, pb, p;
    logic [MW:0]     m;
    logic            rnd, er, zero;
    logic [FLEN-1:0] r;
    logic [FLEN+1:0] q;
    int              e;

    // subnormals flush to zero; overflow and NaN/Inf operands report error
    always_comb begin
        pa = '0;
        pb = '0;
        pa[MW:0] = {1'b1, a[MW-1:0]};
        pb[MW:0] = {1'b1, b[MW-1:0]};
        p = pa * pb;
        e = int'(a[FLEN-2:MW]) + int'(b[FLEN-2:MW]) - BIAS;
        if (p[2*MW+1]) begin
            m   = {1'b0, p[2*MW:MW+1]};
            rnd = p[MW] & ((|p[MW-1:0]) | p[MW+1]);
            e   = e + 1;
        end else begin
            m   = {1'b0, p[2*MW-1:MW]};
            rnd = p[MW-1] & ((|p[MW-2:0]) | p[MW]);
        end
        m = m + {{MW{1'b0}}, rnd};
        if (m[MW]) e = e + 1;
        er   = (&a[FLEN-2:MW]) | (&b[FLEN-2:MW]);
        zero = (a[FLEN-2:MW] == '0) | (b[FLEN-2:MW] == '0);
        r    = '0;
        if (!er && !zero && e > 0) begin
            if (e >= EMAX) er = 1'b1;
            else           r  = {a[FLEN-1] ^ b[FLEN-1], e[EW-1:0], m[MW-1:0]};
        end
    end

    hp_delay #(.W(FLEN + 2), .N(LAT)) u_pipe (
        .clk(clk), .rst_n(~rst), .d({r, er & up_valid, up_valid}), .q(q), .vld_any(busy)
    );

    assign down_valid = q[0];
    assign error      = q[1];
    assign result     = q[FLEN+1:2];
endmodule

module f_add #(
    parameter int FLEN = 64,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            down_valid,
    output logic [FLEN-1:0] result,
    output logic            error,
    output logic            busy
);
    localparam int EW   = (FLEN == 32) ? 8 : 11;
    localparam int MW   = FLEN - 1 - EW;
    localparam int EMAX = (1 << EW) - 1;

    logic [FLEN-1:0] big, sml, r;
    logic [EW-1:0]   ea, eb;
    logic [MW+3:0]   ma, mb, mbs;
    logic [MW+4:0]   w;
    logic [MW:0]     m;
    logic            er;
    logic [FLEN+1:0] q;
    int              d, e, msb;

    // three extra guard/round/sticky bits below the 1.f mantissa
    always_comb begin
        if (a[FLEN-2:0] >= b[FLEN-2:0]) begin big = a; sml = b; end
        else                            begin big = b; sml = a; end
        ea = big[FLEN-2:MW];
        eb = sml[FLEN-2:MW];
        ma = (ea == '0) ? '0 : {1'b1, big[MW-1:0], 3'b000};
        mb = (eb == '0) ? '0 : {1'b1, sml[MW-1:0], 3'b000};
        d  = int'(ea) - int'(eb);
        if (d >= MW + 4) begin
            mbs = {{(MW+3){1'b0}}, |mb};
        end else begin
            mbs    = mb >> d;
            mbs[0] = mbs[0] | (|(mb & ~({(MW+4){1'b1}} << d)));
        end
        if (big[FLEN-1] == sml[FLEN-1]) w = {1'b0, ma} + {1'b0, mbs};
        else                            w = {1'b0, ma} - {1'b0, mbs};
        e   = int'(ea);
        msb = -1;
        if (w[MW+4]) begin
            w = {1'b0, w[MW+4:2], w[1] | w[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < MW + 4; i++) if (w[i]) msb = i;
            if (msb >= 0) begin
                w = w << (MW + 3 - msb);
                e = e - (MW + 3 - msb);
            end
        end
        m = {1'b0, w[MW+2:3]};
        m = m + {{MW{1'b0}}, w[2] & ((|w[1:0]) | w[3])};
        if (m[MW]) e = e + 1;
        er = (&a[FLEN-2:MW]) | (&b[FLEN-2:MW]);
        r  = '0;
        if (!er && w != '0 && e > 0) begin
            if (e >= EMAX) er = 1'b1;
            else           r  = {big[FLEN-1], e[EW-1:0], m[MW-1:0]};
        end
    end

    hp_delay #(.W(FLEN + 2), .N(LAT)) u_pipe (
        .clk(clk), .rst_n(~rst), .d({r, er & up_valid, up_valid}), .q(q), .vld_any(busy)
    );

    assign down_valid = q[0];
    assign error      = q[1];
    assign result     = q[FLEN+1:2];
endmodule

module float_horner_pipe #(
    parameter int DEGREE  = 2,
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    float_horner_pipe_if.slave bus
);
    localparam int FLEN = `FLEN;
    localparam int EW   = (FLEN == 32) ? 8 : 11;
    localparam int CB   = FLEN + 2;
    localparam int CW   = CB + (DEGREE + 1) * FLEN;

    // carried word layout: {coef, x, err, vld}
    logic [CW-1:0]       s0;
    logic [CW-1:0]       stg [DEGREE+1];
    logic [FLEN-1:0]     acc [DEGREE+1];
    logic [4*DEGREE-1:0] unit_busy;
    logic                err_in;
    logic                res_vld_q, res_neg_q, err_q;
    logic [FLEN-1:0]     res_q;

    always_comb begin
        err_in = &bus.x[FLEN-2 -: EW];
        for (int i = 0; i <= DEGREE; i++) err_in = err_in | (&bus.coef[i*FLEN + FLEN-2 -: EW]);
        err_in = err_in & bus.arg_vld;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s0 <= '0;
        else      s0 <= {bus.coef, bus.x, err_in, bus.arg_vld};
    end

    assign stg[0] = s0;
    assign acc[0] = s0[CB + DEGREE*FLEN +: FLEN];

    for (genvar k = 1; k <= DEGREE; k++) begin : g_stage
        logic [CW-1:0]   mid, mid_e, post;
        logic [FLEN-1:0] prod, sum;
        logic            m_dv, m_err, m_busy, m_vany;
        logic            a_dv, a_err, a_busy, a_vany;

        f_mult #(.FLEN(FLEN), .LAT(MUL_LAT)) u_mul (
            .clk(clk), .rst(~rst), .up_valid(stg[k-1][0]), .a(acc[k-1]), .b(stg[k-1][2 +: FLEN]),
            .down_valid(m_dv), .result(prod), .error(m_err), .busy(m_busy)
        );
        hp_delay #(.W(CW), .N(MUL_LAT)) u_carry_mul (
            .clk(clk), .rst_n(rst), .d(stg[k-1]), .q(mid), .vld_any(m_vany)
        );
        assign mid_e = {mid[CW-1:2], mid[1] | (m_dv & m_err), mid[0]};

        f_add #(.FLEN(FLEN), .LAT(ADD_LAT)) u_add (
            .clk(clk), .rst(~rst), .up_valid(mid[0]), .a(prod), .b(mid[CB + (DEGREE-k)*FLEN +: FLEN]),
            .down_valid(a_dv), .result(sum), .error(a_err), .busy(a_busy)
        );
        hp_delay #(.W(CW), .N(ADD_LAT)) u_carry_add (
            .clk(clk), .rst_n(rst), .d(mid_e), .q(post), .vld_any(a_vany)
        );

        assign stg[k] = {post[CW-1:2], post[1] | (a_dv & a_err), post[0]};
        assign acc[k] = sum;
        assign unit_busy[4*(k-1) +: 4] = {m_busy, a_busy, m_vany, a_vany};

        a_mul_step: assert property (@(posedge clk) disable iff (!rst) m_dv == mid[0])
            else $error("f_mult down_valid out of step at stage %0d", k);
        a_add_step: assert property (@(posedge clk) disable iff (!rst) a_dv == post[0])
            else $error("f_add down_valid out of step at stage %0d", k);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
            res_neg_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            res_vld_q <= stg[DEGREE][0];
            res_q     <= stg[DEGREE][1] ? '0 : acc[DEGREE];
            res_neg_q <= !stg[DEGREE][1] & acc[DEGREE][FLEN-1];
`ifdef FLOAT_HORNER_ERR_STICKY_EN
            err_q     <= err_q | stg[DEGREE][1];
`else
            err_q     <= stg[DEGREE][1];
`endif
        end
    end

    assign bus.res_vld      = res_vld_q;
    assign bus.res          = res_q;
    assign bus.res_negative = res_neg_q;
    assign bus.err          = err_q;
    assign bus.busy         = s0[0] | (|unit_busy);
endmodule

// File: tb/tb_float_horner_pipe.sv
// tb/tb_float_horner_pipe.sv - self-checking bench for float_horner_pipe (FP64, DEGREE=2)
`ifndef FLEN
`define FLEN 64
`endif

module tb_float_horner_pipe;
    localparam int L  = 14;
    localparam int NC = 1024;

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] M9   = 64'hC022000000000000;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    float_horner_pipe_if #(.FLEN(64), .DEGREE(2)) bus ();

    float_horner_pipe #(.DEGREE(2), .MUL_LAT(3), .ADD_LAT(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        exp_vld [NC];
    logic        exp_err [NC];
    logic [63:0] exp_res [NC];
    int          n_pass = 0;
    int          n_chk  = 0;
    logic        sticky_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endtask

    function automatic logic special(input logic [63:0] v);
        return v[62:52] == 11'h7FF;
    endfunction

    // drives one input slot; a valid set books its result L cycles later
    task automatic drive(input logic v, input logic [63:0] xv, input logic [63:0] c0,
                         input logic [63:0] c1, input logic [63:0] c2);
        real  xr, p;
        logic e;
        @(posedge clk);
        #1;
        bus.arg_vld = v;
        bus.x       = xv;
        bus.coef    = {c2, c1, c0};
        if (v) begin
            e  = special(xv) | special(c0) | special(c1) | special(c2);
            xr = $bitstoreal(xv);
            p  = $bitstoreal(c0) + $bitstoreal(c1) * xr + $bitstoreal(c2) * xr * xr;
            exp_vld[cyc + L] = 1'b1;
            exp_err[cyc + L] = e;
            exp_res[cyc + L] = e ? 64'h0 : $realtobits(p);
        end
    endtask

    task automatic to_neg(input int c);
        repeat (c - cyc) @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : cmp
        logic e_err;
        if (!rst) begin
            sticky_m = 1'b0;
            check("reset_res_vld", bus.res_vld, 0);
            check("reset_res", bus.res, 0);
            check("reset_err", bus.err, 0);
        end else begin
            if (exp_vld[cyc]) sticky_m = sticky_m | exp_err[cyc];
            check("res_vld", bus.res_vld, exp_vld[cyc]);
            if (exp_vld[cyc]) begin
                check("res", bus.res, exp_res[cyc]);
                check("res_negative", bus.res_negative, exp_res[cyc][63]);
            end
`ifdef FLOAT_HORNER_ERR_STICKY_EN
            e_err = sticky_m;
`else
            e_err = exp_vld[cyc] & exp_err[cyc];
`endif
            check("err", bus.err, e_err);
        end
    end

    initial begin
        int t;
        for (int i = 0; i < NC; i++) begin
            exp_vld[i] = 1'b0;
            exp_err[i] = 1'b0;
            exp_res[i] = 64'h0;
        end
        bus.arg_vld = 1'b0;
        bus.x       = '0;
        bus.coef    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("busy_after_reset", bus.busy, 0);

        // 1: p(2) = 1 + 2 + 4 = 7
        drive(1, TWO, ONE, ONE, ONE);
        t = cyc;
        drive(0, 0, 0, 0, 0);
        to_neg(t + L - 1);
        check("t1_not_early", bus.res_vld, 0);
        to_neg(t + L);
        check("t1_vld", bus.res_vld, 1);
        check("t1_res", bus.res, 64'h401C000000000000);
        check("t1_neg", bus.res_negative, 0);

        // 2: p(2) = -9 + 2 + 4 = -3
        drive(1, TWO, M9, ONE, ONE);
        t = cyc;
        drive(0, 0, 0, 0, 0);
        to_neg(t + L);
        check("t2_res", bus.res, 64'hC008000000000000);
        check("t2_neg", bus.res_negative, 1);

        // 6: gaps with NaN data on idle slots
        drive(1, 64'h4008000000000000, ONE, ONE, ONE);
        t = cyc;
        drive(0, QNAN, QNAN, QNAN, QNAN);
        drive(1, 64'h3FE0000000000000, ONE, ONE, ONE);
        drive(1, 64'hBFF0000000000000, ONE, ONE, ONE);
        drive(0, QNAN, QNAN, QNAN, QNAN);
        drive(0, 0, 0, 0, 0);
        to_neg(t + L);
        check("t6_res_x3", bus.res, 64'h402A000000000000);
        to_neg(t + L + 1);
        check("t6_gap", bus.res_vld, 0);
        to_neg(t + L + 2);
        check("t6_res_xhalf", bus.res, 64'h3FFC000000000000);
        to_neg(t + L + 5);

        // 3: 20 back-to-back sets, x = 0..19
        for (int i = 0; i < 20; i++) begin
            drive(1, $realtobits(real'(i)), ONE, ONE, ONE);
            if (i == 0) t = cyc;
            else begin
                @(negedge clk);
                check("t3_busy", bus.busy, 1);
            end
        end
        drive(0, 0, 0, 0, 0);
        to_neg(t + L + 19);
        check("t3_last_res", bus.res, 64'h4077D00000000000);
        to_neg(t + L + 21);
        check("t3_busy_drained", bus.busy, 0);

        // 4: +Inf coefficient, then a clean set
        drive(1, TWO, ONE, PINF, ONE);
        t = cyc;
        drive(1, TWO, ONE, ONE, ONE);
        drive(0, 0, 0, 0, 0);
        to_neg(t + L);
        check("t4_vld", bus.res_vld, 1);
        check("t4_err", bus.err, 1);
        check("t4_res_zero", bus.res, 0);
        to_neg(t + L + 1);
        check("t4_clean_res", bus.res, 64'h401C000000000000);
`ifdef FLOAT_HORNER_ERR_STICKY_EN
        check("t4_clean_err", bus.err, 1);
`else
        check("t4_clean_err", bus.err, 0);
`endif
        to_neg(t + L + 3);

        // 5: reset pulled mid-stream drops every in-flight token
        for (int i = 0; i < 4; i++) drive(1, $realtobits(real'(i + 1)), ONE, ONE, ONE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.arg_vld = 1'b1;
        for (int i = cyc; i < NC; i++) exp_vld[i] = 1'b0;
        #1;
        check("t5_rst_vld", bus.res_vld, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_err", bus.err, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.arg_vld = 1'b0;
        @(negedge clk);
        check("t5_busy_release", bus.busy, 0);
        drive(1, TWO, ONE, ONE, ONE);
        t = cyc;
        drive(0, 0, 0, 0, 0);
        to_neg(t + L - 1);
        check("t5_not_early", bus.res_vld, 0);
        to_neg(t + L);
        check("t5_vld", bus.res_vld, 1);
        check("t5_res", bus.res, 64'h401C000000000000);
        check("t5_err", bus.err, 0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
